// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Request/response bundle between a requester and alu_sequencer.
//   Request : req_valid, req_ready, opcode, funct, shamt, imm, rs_val, rt_val
//   Response: resp_valid, resp_ready, result, ovf, branch_taken, illegal
// Modports:
//   slave  - the sequencer (accepts requests, produces responses)
//   master - the requester/consumer side
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              branch_taken;
    logic              illegal;

    modport slave (
        input  req_valid, opcode, funct, shamt, imm, rs_val, rt_val, resp_ready,
        output req_ready, resp_valid, result, ovf, branch_taken, illegal
    );

    modport master (
        output req_valid, opcode, funct, shamt, imm, rs_val, rt_val, resp_ready,
        input  req_ready, resp_valid, result, ovf, branch_taken, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Initiator-side controller for a 3-bit-select combinational ALU. Takes one
// decoded MIPS-subset operation at a time, drives the ALU, and returns a
// registered result, overflow and branch decision. Variable-amount SLL is
// built by iterating the ALU's shift-by-one select.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   bus (slave)        - request/response handshake bundle
//   alu_a/alu_b/alu_sel- registered ALU drive
//   alu_f/alu_ovf/alu_zero - ALU outputs, sampled at the edge ending EXEC/SHIFT
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_zero
);
    localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(3'b000);
    localparam logic [SEL_W-1:0] SEL_AND = SEL_W'(3'b010);
    localparam logic [SEL_W-1:0] SEL_OR  = SEL_W'(3'b011);
    localparam logic [SEL_W-1:0] SEL_SLT = SEL_W'(3'b100);
    localparam logic [SEL_W-1:0] SEL_SLL = SEL_W'(3'b101);
    localparam logic [SEL_W-1:0] SEL_BEQ = SEL_W'(3'b110);
    localparam logic [SEL_W-1:0] SEL_BNE = SEL_W'(3'b111);
    // AND of zeros keeps f driven while the ALU is parked.
    localparam logic [SEL_W-1:0] SEL_PARK = SEL_AND;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;
    // K_ADD carries the overflow flag; K_LOGIC covers AND/OR/SLT.
    typedef enum logic [2:0] {K_ADD, K_LOGIC, K_BRANCH, K_SLL, K_ILLEGAL} kind_t;

    state_t            state;
    kind_t             kind_q;
    logic [4:0]        cnt;

    kind_t             dec_kind;
    logic [SEL_W-1:0]  dec_sel;
    logic [DATA_W-1:0] dec_b;

    // Decode of the request currently presented on the bus.
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statements can infer a latch.
    always_comb begin
        dec_kind = K_ILLEGAL;
        dec_sel  = SEL_PARK;
        dec_b    = bus.rt_val;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20: begin dec_kind = K_ADD;   dec_sel = SEL_ADD; end
                    6'h24: begin dec_kind = K_LOGIC; dec_sel = SEL_AND; end
                    6'h25: begin dec_kind = K_LOGIC; dec_sel = SEL_OR;  end
                    6'h2A: begin dec_kind = K_LOGIC; dec_sel = SEL_SLT; end
                    6'h00: begin dec_kind = K_SLL;   dec_sel = SEL_SLL; end
                    default: dec_kind = K_ILLEGAL;
                endcase
            end
            6'h08: begin
                dec_kind = K_ADD;
                dec_sel  = SEL_ADD;
                dec_b    = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
            end
            6'h04: begin dec_kind = K_BRANCH; dec_sel = SEL_BEQ; end
            6'h05: begin dec_kind = K_BRANCH; dec_sel = SEL_BNE; end
            default: dec_kind = K_ILLEGAL;
        endcase
    end

    // Single-process FSM. The ALU operand registers double as the latched
    // operands; in SHIFT, alu_a is the running accumulator.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register, including operands and counter, is reset
            // so an aborted operation leaves nothing behind.
            state            <= S_IDLE;
            kind_q           <= K_ADD;
            cnt              <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_sel          <= SEL_PARK;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.result       <= '0;
            bus.ovf          <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        kind_q        <= dec_kind;
                        case (dec_kind)
                            K_ILLEGAL: begin
                                bus.illegal    <= 1'b1;
                                bus.result     <= '0;
                                bus.resp_valid <= 1'b1;
                                state          <= S_DONE;
                            end
                            K_SLL: begin
                                if (bus.shamt == 5'd0) begin
                                    bus.result     <= bus.rt_val;
                                    bus.resp_valid <= 1'b1;
                                    state          <= S_DONE;
                                end else begin
                                    alu_a   <= bus.rt_val;
                                    alu_b   <= '0;
                                    alu_sel <= SEL_SLL;
                                    cnt     <= bus.shamt;
                                    state   <= S_SHIFT;
                                end
                            end
                            default: begin
                                alu_a   <= bus.rs_val;
                                alu_b   <= dec_b;
                                alu_sel <= dec_sel;
                                state   <= S_EXEC;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    // BEQ/BNE leave f undefined, so only the flag is used.
                    if (kind_q == K_BRANCH) begin
                        bus.result       <= '0;
                        bus.branch_taken <= alu_zero;
                    end else begin
                        bus.result <= alu_f;
                    end
                    bus.ovf        <= (kind_q == K_ADD) && alu_ovf;
                    bus.resp_valid <= 1'b1;
                    alu_a          <= '0;
                    alu_b          <= '0;
                    alu_sel        <= SEL_PARK;
                    state          <= S_DONE;
                end
                S_SHIFT: begin
                    if (cnt == 5'd1) begin
                        bus.result     <= alu_f;
                        bus.resp_valid <= 1'b1;
                        alu_a          <= '0;
                        alu_sel        <= SEL_PARK;
                        state          <= S_DONE;
                    end else begin
                        alu_a <= alu_f;
                    end
                    cnt <= cnt - 5'd1;
                end
                S_DONE: begin
                    // Returning to IDLE with req_ready set guarantees one
                    // IDLE cycle before the next request can be taken.
                    if (bus.resp_ready) begin
                        bus.resp_valid   <= 1'b0;
                        bus.result       <= '0;
                        bus.ovf          <= 1'b0;
                        bus.branch_taken <= 1'b0;
                        bus.illegal      <= 1'b0;
                        bus.req_ready    <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer: a behavioural ALU, a table of
// directed vectors, hand-written backpressure and reset sequences, and
// randomized operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] alu_a, alu_b, alu_f;
    logic [SEL_W-1:0]  alu_sel;
    logic              alu_ovf, alu_zero;

    alu_sequencer_if #(.DATA_W(DATA_W)) bus ();

    alu_sequencer #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_f    (alu_f),
        .alu_ovf  (alu_ovf),
        .alu_zero (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. BEQ/BNE produce a junk f to prove it is ignored.
    always_comb begin
        alu_f    = 32'h0;
        alu_ovf  = 1'b0;
        alu_zero = 1'b0;
        case (alu_sel)
            3'b000: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b010: alu_f = alu_a & alu_b;
            3'b011: alu_f = alu_a | alu_b;
            3'b100: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b101: alu_f = {alu_a[30:0], 1'b0};
            3'b110: alu_f = 32'hDEADBEEF;
            3'b111: alu_f = 32'hDEADBEEF;
            default: alu_f = 32'hBAD0BAD0;
        endcase
        if (alu_sel == 3'b110)      alu_zero = (alu_a == alu_b);
        else if (alu_sel == 3'b111) alu_zero = (alu_a != alu_b);
        else                        alu_zero = (alu_f == 32'h0);
    end

    // Sticky flag: select 001 (f undriven) must never appear.
    logic bad_sel_seen;
    initial bad_sel_seen = 1'b0;
    always @(negedge clk) if (alu_sel == 3'b001) bad_sel_seen = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        br;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    // Reference model: expected response computed straight from the
    // instruction semantics with plain arithmetic.
    function automatic exp_t ref_model(input vec_t v);
        exp_t   e;
        longint s;
        logic [31:0] b;
        e = '{result: 32'h0, ovf: 1'b0, br: 1'b0, ill: 1'b0, lat: 2};
        b = (v.op == 6'h08) ? {{16{v.imm[15]}}, v.imm} : v.rt;
        if ((v.op == 6'h00 && v.funct == 6'h20) || v.op == 6'h08) begin
            s        = longint'($signed(v.rs)) + longint'($signed(b));
            e.result = 32'(s);
            e.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (v.op == 6'h00 && v.funct == 6'h24) e.result = v.rs & v.rt;
        else if (v.op == 6'h00 && v.funct == 6'h25)     e.result = v.rs | v.rt;
        else if (v.op == 6'h00 && v.funct == 6'h2A)     e.result = {31'b0, $signed(v.rs) < $signed(v.rt)};
        else if (v.op == 6'h00 && v.funct == 6'h00) begin
            e.result = v.rt << v.shamt;
            e.lat    = (v.shamt == 0) ? 1 : int'(v.shamt) + 1;
        end else if (v.op == 6'h04) e.br = (v.rs == v.rt);
        else if (v.op == 6'h05)     e.br = (v.rs != v.rt);
        else begin
            e.ill = 1'b1;
            e.lat = 1;
        end
        return e;
    endfunction

    task automatic drive_fields(input vec_t v);
        bus.opcode = v.op;
        bus.funct  = v.funct;
        bus.shamt  = v.shamt;
        bus.imm    = v.imm;
        bus.rs_val = v.rs;
        bus.rt_val = v.rt;
    endtask

    // Present a request at the falling edge; it is accepted at the next rise.
    task automatic issue(input vec_t v);
        @(negedge clk);
        drive_fields(v);
        bus.req_valid = 1'b1;
        check({v.name, " req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts edges until resp_valid.
    task automatic wait_resp(input string name, input int exp_lat);
        int edges = 1;
        while (bus.resp_valid !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, " latency"}, 32'(edges), 32'(exp_lat));
    endtask

    task automatic check_resp(input string name, input exp_t e);
        check({name, " result"},  bus.result,             e.result);
        check({name, " ovf"},     {31'b0, bus.ovf},          {31'b0, e.ovf});
        check({name, " branch"},  {31'b0, bus.branch_taken}, {31'b0, e.br});
        check({name, " illegal"}, {31'b0, bus.illegal},      {31'b0, e.ill});
    endtask

    task automatic complete(input string name);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({name, " resp_valid cleared"}, {31'b0, bus.resp_valid}, 32'd0);
        check({name, " idle req_ready"},     {31'b0, bus.req_ready},  32'd1);
        check({name, " idle alu_sel"},       {29'b0, alu_sel},        32'd2);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v);
        wait_resp(v.name, v.e.lat);
        check_resp(v.name, v.e);
        complete(v.name);
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] funct,
                                input logic [4:0] shamt, input logic [15:0] imm,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] res, input logic ovf, input logic br,
                                input logic ill, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.shamt = shamt; v.imm = imm;
        v.rs = rs; v.rt = rt;
        v.e = '{result: res, ovf: ovf, br: br, ill: ill, lat: lat};
        return v;
    endfunction

    vec_t table_v[$];

    initial begin
        vec_t v;
        int   stale;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.shamt = '0; bus.imm = '0;
        bus.rs_val = '0; bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("reset result",     bus.result,              32'd0);
        check("reset flags", {29'b0, bus.ovf, bus.branch_taken, bus.illegal}, 32'd0);
        check("reset alu_a",      alu_a,                   32'd0);
        check("reset alu_b",      alu_b,                   32'd0);
        check("reset alu_sel",    {29'b0, alu_sel},        32'd2);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        table_v.push_back(mk("add_ovf",   6'h00, 6'h20, 5'd0,  16'h0,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 0, 2));
        table_v.push_back(mk("sll4",      6'h00, 6'h00, 5'd4,  16'h0,    32'h0,        32'h0000000F, 32'h000000F0, 0, 0, 0, 5));
        table_v.push_back(mk("sll31",     6'h00, 6'h00, 5'd31, 16'h0,    32'h0,        32'h00000001, 32'h80000000, 0, 0, 0, 32));
        table_v.push_back(mk("sll0",      6'h00, 6'h00, 5'd0,  16'h0,    32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 1));
        table_v.push_back(mk("sll_lost",  6'h00, 6'h00, 5'd1,  16'h0,    32'h0,        32'h80000001, 32'h00000002, 0, 0, 0, 2));
        table_v.push_back(mk("slt_neg",   6'h00, 6'h2A, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 2));
        table_v.push_back(mk("slt_pos",   6'h00, 6'h2A, 5'd0,  16'h0,    32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 2));
        table_v.push_back(mk("beq_eq",    6'h04, 6'h00, 5'd0,  16'h0,    32'h00001234, 32'h00001234, 32'h0, 0, 1, 0, 2));
        table_v.push_back(mk("bne_eq",    6'h05, 6'h00, 5'd0,  16'h0,    32'h00001234, 32'h00001234, 32'h0, 0, 0, 0, 2));
        table_v.push_back(mk("bne_ne",    6'h05, 6'h00, 5'd0,  16'h0,    32'h00000001, 32'h00000002, 32'h0, 0, 1, 0, 2));
        table_v.push_back(mk("addi_neg",  6'h08, 6'h00, 5'd0,  16'hFFFF, 32'h00000005, 32'h00000055, 32'h00000004, 0, 0, 0, 2));
        table_v.push_back(mk("addi_ovf",  6'h08, 6'h00, 5'd0,  16'h7FFF, 32'h7FFFFFFF, 32'h0,        32'h80007FFE, 1, 0, 0, 2));
        table_v.push_back(mk("ill_sub",   6'h00, 6'h22, 5'd0,  16'h0,    32'h00000009, 32'h00000003, 32'h0, 0, 0, 1, 1));
        table_v.push_back(mk("ill_lw",    6'h23, 6'h20, 5'd0,  16'h0,    32'h00000009, 32'h00000003, 32'h0, 0, 0, 1, 1));
        table_v.push_back(mk("and",       6'h00, 6'h24, 5'd0,  16'h0,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 2));
        table_v.push_back(mk("or",        6'h00, 6'h25, 5'd0,  16'h0,    32'hF0000000, 32'h0000000F, 32'hF000000F, 0, 0, 0, 2));
        table_v.push_back(mk("add_neg",   6'h00, 6'h20, 5'd0,  16'h0,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 2));
        foreach (table_v[i]) run_vec(table_v[i]);

        // Backpressure: response held for 3 cycles while a new request waits.
        v = mk("bp_first", 6'h00, 6'h20, 5'd0, 16'h0, 32'd10, 32'd20, 32'd30, 0, 0, 0, 2);
        issue(v);
        wait_resp(v.name, 2);
        check_resp(v.name, v.e);
        v = mk("bp_second", 6'h00, 6'h20, 5'd0, 16'h0, 32'd3, 32'd4, 32'd7, 0, 0, 0, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_fields(v);
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d resp_valid", c), {31'b0, bus.resp_valid}, 32'd1);
            check($sformatf("bp hold%0d req_ready", c),  {31'b0, bus.req_ready},  32'd0);
            check($sformatf("bp hold%0d result", c),     bus.result,              32'd30);
            check($sformatf("bp hold%0d ovf", c),        {31'b0, bus.ovf},        32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("bp release resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("bp release req_ready",  {31'b0, bus.req_ready},  32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(v.name, 2);
        check_resp(v.name, v.e);
        complete(v.name);

        // Reset in the middle of a 20-step shift.
        v = mk("rst_shift", 6'h00, 6'h00, 5'd20, 16'h0, 32'h0, 32'h00000001, 32'h0, 0, 0, 0, 21);
        issue(v);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_shift req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rst_shift resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_shift alu_sel",    {29'b0, alu_sel},        32'd2);
        check("rst_shift alu_a",      alu_a,                   32'd0);
        stale = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) stale++;
        end
        check("rst_shift stale responses", 32'(stale), 32'd0);
        run_vec(mk("post_rst_add", 6'h00, 6'h20, 5'd0, 16'h0, 32'd100, 32'd23, 32'd123, 0, 0, 0, 2));

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 8);
            v.name  = $sformatf("rnd%0d", n);
            v.shamt = 5'($urandom_range(0, 31));
            v.imm   = 16'($urandom);
            v.rs    = $urandom;
            v.rt    = ($urandom_range(0, 1) == 1) ? v.rs : $urandom;
            v.op    = 6'h00;
            case (k)
                0: v.funct = 6'h20;
                1: v.funct = 6'h24;
                2: v.funct = 6'h25;
                3: v.funct = 6'h2A;
                4: v.funct = 6'h00;
                5: begin v.op = 6'h08; v.funct = 6'($urandom); end
                6: begin v.op = 6'h04; v.funct = 6'($urandom); end
                7: begin v.op = 6'h05; v.funct = 6'($urandom); end
                default: begin v.op = 6'h23; v.funct = 6'h20; end
            endcase
            v.e = ref_model(v);
            run_vec(v);
        end

        check("alu select 001 never driven", {31'b0, bad_sel_seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
